// File: rtl/spi_master_core.sv
// SPI master: one word per cmd handshake, CS held across words until cmd_last; response in a one-entry holding register.
// Latency: rsp_valid 1+H+2*DATA_W*H cycles after an IDLE accept. A full response register stalls the FSM in RSPWAIT with SCK idle.
module spi_master_core #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8,
    parameter int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [CSW-1:0]    cfg_cs_sel,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_last,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int ECW = $clog2(2 * DATA_W + 1);
    localparam logic [ECW-1:0] LAST_EC = ECW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, ASSERT, SHIFT, RSPWAIT, GAP, DEASSERT} state_t;
    state_t state, state_nxt;

    logic              cpol_q, cpha_q, lsb_q, last_q;
    logic [DIV_W-1:0]  div_q, hcnt;
    logic [ECW-1:0]    ec;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_next, rx_word;
    logic              accept, half_done, edge_ev, last_edge, leading, rsp_free;
    logic              cpha_eff, lsb_eff;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    // Out-of-range selects decode to no active chip select.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
        logic [NUM_CS-1:0] d;
        d = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(sel) == i) d[i] = 1'b0;
        return d;
    endfunction

    assign cmd_ready = (state == IDLE) || (state == GAP);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign half_done = (hcnt == div_q);
    assign edge_ev   = (state == SHIFT) && half_done;
    assign last_edge = edge_ev && (ec == LAST_EC);
    assign leading   = ~ec[0];
    assign rsp_free  = !rsp_valid || rsp_ready;
    assign cpha_eff  = (state == IDLE) ? cfg_cpha : cpha_q;
    assign lsb_eff   = (state == IDLE) ? cfg_lsb_first : lsb_q;
    assign rx_next   = lsb_q ? {spi_miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], spi_miso};
    // With cpha=1 the final bit arrives on the closing trailing edge itself.
    assign rx_word   = cpha_q ? rx_next : rx_sr;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_valid) state_nxt = ASSERT;
            ASSERT:   if (half_done) state_nxt = SHIFT;
            SHIFT:    if (last_edge) state_nxt = !rsp_free ? RSPWAIT : (last_q ? DEASSERT : GAP);
            RSPWAIT:  if (rsp_ready) state_nxt = last_q ? DEASSERT : GAP;
            GAP:      if (cmd_valid) state_nxt = SHIFT;
            DEASSERT: if (half_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            last_q    <= 1'b0;
            div_q     <= '0;
            hcnt      <= '0;
            ec        <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            spi_cs_n  <= '1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            hcnt <= (state_nxt != state || half_done) ? '0 : hcnt + 1'b1;
            ec   <= (state == SHIFT) ? (edge_ev ? ec + 1'b1 : ec) : '0;

            if (accept && state == IDLE) spi_sck <= cfg_cpol;
            else if (edge_ev)            spi_sck <= ~spi_sck;
            else if (state != SHIFT)     spi_sck <= cpol_q;

            if (accept) begin
                if (state == IDLE) begin
                    cpol_q   <= cfg_cpol;
                    cpha_q   <= cfg_cpha;
                    lsb_q    <= cfg_lsb_first;
                    div_q    <= cfg_div;
                    spi_cs_n <= cs_decode(cfg_cs_sel);
                end
                last_q <= cmd_last;
                if (cpha_eff) begin
                    tx_sr <= cmd_data;
                end else begin
                    spi_mosi <= first_bit(cmd_data, lsb_eff);
                    tx_sr    <= shift_out(cmd_data, lsb_eff);
                end
            end

            if (edge_ev && !last_edge && (leading == cpha_q)) begin
                spi_mosi <= first_bit(tx_sr, lsb_q);
                tx_sr    <= shift_out(tx_sr, lsb_q);
            end
            if (edge_ev && (leading != cpha_q)) rx_sr <= rx_next;

            if (state_nxt == DEASSERT && state != DEASSERT) spi_cs_n <= '1;

            if (last_edge && rsp_free) begin
                rsp_data  <= rx_word;
                rsp_valid <= 1'b1;
            end else if (state == RSPWAIT && rsp_ready) begin
                rsp_data  <= rx_sr;
                rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: loopback and a simple mode-3 slave, cycle-accurate frame timing.
module tb_spi_master_core;

    logic       axi_aclk = 1'b0;
    logic       axi_aresetn = 1'b0;
    logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic [1:0] cfg_cs_sel = 2'd0;
    logic       cmd_valid = 1'b0, cmd_last = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, rsp_valid, busy, spi_sck, spi_mosi, spi_miso;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [1:0] spi_cs_n;

    logic       loop_en = 1'b1;
    logic [7:0] slave_word = 8'h00;
    logic       miso_s;
    int         nfall = 0;

    int n_checks = 0, n_fail = 0;

    // CSW widened to 2 so a select beyond NUM_CS can be driven.
    spi_master_core #(.DATA_W(8), .NUM_CS(2), .DIV_W(8), .CSW(2)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
        .cfg_div(cfg_div), .cfg_cs_sel(cfg_cs_sel),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 axi_aclk = ~axi_aclk;

    // Slave drives the next bit on each falling SCK (mode 3 leading edge), MSB first.
    always @(negedge spi_sck or posedge spi_cs_n[0]) begin
        if (spi_cs_n[0]) nfall = 0;
        else             nfall = nfall + 1;
    end
    assign miso_s   = (nfall >= 1 && nfall <= 8) ? slave_word[3'(8 - nfall)] : 1'b0;
    assign spi_miso = loop_en ? spi_mosi : miso_s;

    int   cyc = 0, sck_rise = 0, cs_low0 = 0, cs_low1 = 0, cs1_rise = 0, both_low = 0;
    int   rsp_n = 0, rsp_rise_cyc = -1, rise_prev = 0, rise_last = 0;
    logic sck_p = 1'b0, cs1_p = 1'b1, rv_p = 1'b0;
    logic [7:0] rsp_log [16];

    always @(negedge axi_aclk) begin
        cyc = cyc + 1;
        if (spi_sck && !sck_p) begin
            sck_rise  = sck_rise + 1;
            rise_prev = rise_last;
            rise_last = cyc;
        end
        if (!spi_cs_n[0]) cs_low0 = cs_low0 + 1;
        if (!spi_cs_n[1]) cs_low1 = cs_low1 + 1;
        if (spi_cs_n[1] && !cs1_p) cs1_rise = cs1_rise + 1;
        if (spi_cs_n === 2'b00) both_low = both_low + 1;
        if (rsp_valid && !rv_p) rsp_rise_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
            rsp_log[rsp_n % 16] = rsp_data;
            rsp_n = rsp_n + 1;
        end
        sck_p = spi_sck;
        cs1_p = spi_cs_n[1];
        rv_p  = rsp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic pol, input logic pha, input logic lsb, input logic [7:0] div, input logic [1:0] sel);
        cfg_cpol = pol; cfg_cpha = pha; cfg_lsb_first = lsb; cfg_div = div; cfg_cs_sel = sel;
    endtask

    // Returns the cycle-0 index; the caller is left at cycle 1.
    task automatic send(input logic [7:0] d, input logic l, output int acc);
        cmd_data = d; cmd_last = l; cmd_valid = 1'b1; acc = -1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                @(posedge axi_aclk);
                #1;
                acc = cyc;
                break;
            end
            @(posedge axi_aclk);
            #1;
        end
        cmd_valid = 1'b0;
        n_checks++; if (acc < 0) begin n_fail++; $display("FAIL send_timeout data=%h cmd_ready never seen", d); end
    endtask

    task automatic pop();
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++; if (spi_cs_n !== 2'b11) begin n_fail++; $display("FAIL rst_cs got=%b exp=11", spi_cs_n); end
        n_checks++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL rst_sck got=%b exp=0", spi_sck); end
        n_checks++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi got=%b exp=0", spi_mosi); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=00", rsp_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        axi_aresetn = 1'b1;
        tick(1);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_mode0_loopback();
        int acc, r0, c0;
        set_cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        loop_en = 1'b1;
        r0 = sck_rise; c0 = cs_low0;
        send(8'hA5, 1'b1, acc);
        n_checks++; if (spi_cs_n !== 2'b10) begin n_fail++; $display("FAIL m0_cs_c1 got=%b exp=10", spi_cs_n); end
        n_checks++; if (spi_mosi !== 1'b1) begin n_fail++; $display("FAIL m0_mosi_c1 got=%b exp=1", spi_mosi); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL m0_busy got=%b exp=1", busy); end
        tick(18);
        n_checks++; if (rsp_rise_cyc - acc !== 18) begin n_fail++; $display("FAIL m0_rsp_cycle got=%0d exp=18", rsp_rise_cyc - acc); end
        n_checks++; if (sck_rise - r0 !== 8) begin n_fail++; $display("FAIL m0_sck_rises got=%0d exp=8", sck_rise - r0); end
        n_checks++; if (cs_low0 - c0 !== 17) begin n_fail++; $display("FAIL m0_cs_low_cycles got=%0d exp=17", cs_low0 - c0); end
        n_checks++; if (rsp_data !== 8'hA5) begin n_fail++; $display("FAIL m0_rsp_data got=%h exp=a5", rsp_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL m0_idle got=%b exp=0", busy); end
        pop();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL m0_rsp_popped got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_mode3_slave();
        int acc;
        set_cfg(1'b1, 1'b1, 1'b0, 8'd3, 2'd0);
        loop_en = 1'b0; slave_word = 8'h3C;
        send(8'h00, 1'b1, acc);
        n_checks++; if (spi_sck !== 1'b1) begin n_fail++; $display("FAIL m3_sck_idle_c1 got=%b exp=1", spi_sck); end
        tick(73);
        n_checks++; if (rise_last - rise_prev !== 8) begin n_fail++; $display("FAIL m3_sck_period got=%0d exp=8", rise_last - rise_prev); end
        n_checks++; if (rsp_rise_cyc - acc !== 69) begin n_fail++; $display("FAIL m3_rsp_cycle got=%0d exp=69", rsp_rise_cyc - acc); end
        n_checks++; if (rsp_data !== 8'h3C) begin n_fail++; $display("FAIL m3_rsp_data got=%h exp=3c", rsp_data); end
        n_checks++; if (spi_sck !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL m3_idle sck=%b busy=%b exp sck=1 busy=0", spi_sck, busy); end
        pop();
        loop_en = 1'b1;
    endtask

    task automatic test_mode1_loopback();
        int acc;
        set_cfg(1'b0, 1'b1, 1'b0, 8'd1, 2'd0);
        send(8'h96, 1'b1, acc);
        tick(35);
        n_checks++; if (rsp_rise_cyc - acc !== 35) begin n_fail++; $display("FAIL m1_rsp_cycle got=%0d exp=35", rsp_rise_cyc - acc); end
        n_checks++; if (rsp_data !== 8'h96) begin n_fail++; $display("FAIL m1_rsp_data got=%h exp=96", rsp_data); end
        pop();
    endtask

    task automatic test_back_to_back();
        int acc, n0, c0, r1;
        set_cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd1);
        rsp_ready = 1'b1;
        n0 = rsp_n; c0 = cs_low0; r1 = cs1_rise;
        send(8'h12, 1'b0, acc);
        cfg_cs_sel = 2'd0; cfg_lsb_first = 1'b1;
        send(8'h34, 1'b1, acc);
        tick(20);
        rsp_ready = 1'b0;
        n_checks++; if (cs_low0 - c0 !== 0) begin n_fail++; $display("FAIL b2b_cs0_low got=%0d exp=0", cs_low0 - c0); end
        n_checks++; if (cs1_rise - r1 !== 1) begin n_fail++; $display("FAIL b2b_cs1_releases got=%0d exp=1", cs1_rise - r1); end
        n_checks++; if (rsp_n - n0 !== 2) begin n_fail++; $display("FAIL b2b_rsp_count got=%0d exp=2", rsp_n - n0); end
        n_checks++; if (rsp_log[n0 % 16] !== 8'h12) begin n_fail++; $display("FAIL b2b_rsp0 got=%h exp=12", rsp_log[n0 % 16]); end
        n_checks++; if (rsp_log[(n0 + 1) % 16] !== 8'h34) begin n_fail++; $display("FAIL b2b_rsp1 got=%h exp=34", rsp_log[(n0 + 1) % 16]); end
    endtask

    task automatic test_rsp_stall();
        int acc, r0;
        set_cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        send(8'h11, 1'b0, acc);
        send(8'h22, 1'b0, acc);
        tick(30);
        r0 = sck_rise;
        tick(10);
        n_checks++; if (sck_rise - r0 !== 0 || spi_sck !== 1'b0) begin n_fail++; $display("FAIL stall_sck rises=%0d sck=%b exp 0/0", sck_rise - r0, spi_sck); end
        n_checks++; if (spi_cs_n !== 2'b10) begin n_fail++; $display("FAIL stall_cs got=%b exp=10", spi_cs_n); end
        n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_state ready=%b busy=%b exp 0/1", cmd_ready, busy); end
        n_checks++; if (rsp_data !== 8'h11) begin n_fail++; $display("FAIL stall_hold got=%h exp=11", rsp_data); end
        pop();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h22) begin n_fail++; $display("FAIL stall_second v=%b d=%h exp 1/22", rsp_valid, rsp_data); end
        send(8'h33, 1'b1, acc);
        tick(20);
        n_checks++; if (rsp_data !== 8'h22) begin n_fail++; $display("FAIL stall_second_hold got=%h exp=22", rsp_data); end
        pop();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h33) begin n_fail++; $display("FAIL stall_third v=%b d=%h exp 1/33", rsp_valid, rsp_data); end
    endtask

    task automatic test_reset_midframe();
        int acc;
        set_cfg(1'b1, 1'b0, 1'b0, 8'd3, 2'd0);
        send(8'hF0, 1'b1, acc);
        tick(36);
        #2 axi_aresetn = 1'b0;
        #1;
        n_checks++; if (spi_cs_n !== 2'b11 || spi_sck !== 1'b0) begin n_fail++; $display("FAIL mrst_pins cs=%b sck=%b exp 11/0", spi_cs_n, spi_sck); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL mrst_rsp v=%b d=%h exp 0/00", rsp_valid, rsp_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready got=%b exp=1", cmd_ready); end
        set_cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        send(8'h5A, 1'b1, acc);
        tick(18);
        n_checks++; if (rsp_rise_cyc - acc !== 18 || rsp_data !== 8'h5A) begin n_fail++; $display("FAIL mrst_new cyc=%0d d=%h exp 18/5a", rsp_rise_cyc - acc, rsp_data); end
        pop();
    endtask

    task automatic test_lsb_nocs();
        int acc, c0, c1;
        set_cfg(1'b0, 1'b0, 1'b1, 8'd0, 2'd3);
        c0 = cs_low0; c1 = cs_low1;
        send(8'h01, 1'b1, acc);
        n_checks++; if (spi_mosi !== 1'b1) begin n_fail++; $display("FAIL lsb_first_bit got=%b exp=1", spi_mosi); end
        n_checks++; if (spi_cs_n !== 2'b11) begin n_fail++; $display("FAIL nocs_c1 got=%b exp=11", spi_cs_n); end
        tick(18);
        n_checks++; if (rsp_rise_cyc - acc !== 18 || rsp_data !== 8'h01) begin n_fail++; $display("FAIL lsb_rsp cyc=%0d d=%h exp 18/01", rsp_rise_cyc - acc, rsp_data); end
        n_checks++; if (cs_low0 - c0 !== 0 || cs_low1 - c1 !== 0) begin n_fail++; $display("FAIL nocs_low cs0=%0d cs1=%0d exp 0/0", cs_low0 - c0, cs_low1 - c1); end
        pop();
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_mode1_loopback();
        test_back_to_back();
        test_rsp_stall();
        test_reset_midframe();
        test_lsb_nocs();
        n_checks++; if (both_low !== 0) begin n_fail++; $display("FAIL cs_onehot cycles_with_two_low=%0d exp=0", both_low); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
